dmem_lsu: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed data memory in the LAB5 datapath. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake, then drives the memory's `WriteEn`/`ReadEn`/`Address`/`WriteData` and consumes its combinational `ReadData`. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended.

---
 rtl/dmem_lsu_pkg.sv | 25 ++
 rtl/dmem_lsu_lane.sv | 36 +++
 rtl/dmem_lsu.sv | 128 ++++++++++++
 tb/tb_dmem_lsu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - size codes, FSM state encoding and alignment check for dmem_lsu
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Size 11 is reserved and always rejected.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return low[0];
            SZ_WORD: return |low;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// rtl/dmem_lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] old_word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? word[31:16] : word[15:0];
        load_data  = word;
        merge_data = old_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
                merge_data[{lane[1], 4'b0000} +: 16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store FSM in front of the word-addressed data memory
// Optional DMEM_LSU_COUNTERS_EN adds saturating load/store/error counters.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_WriteEn,
    output logic                  mem_ReadEn,
    output logic [ADDR_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
`ifdef DMEM_LSU_COUNTERS_EN
    output logic [15:0]           cnt_load,
    output logic [15:0]           cnt_store,
    output logic [15:0]           cnt_err,
`endif
    input  logic [DATA_WIDTH-1:0] mem_ReadData
);

    state_t                state;
    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] merge;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic                  req_err;

    assign req_err = access_err(req_size, req_addr[1:0]);

    dmem_lsu_lane u_lane (
        .word       (mem_ReadData),
        .size       (lat_size),
        .lane       (lat_addr[1:0]),
        .sign_ext   (lat_signed),
        .old_word   (merge),
        .wdata      (lat_wdata[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Enables come straight from the state register so an async reset kills them at once.
    assign req_ready     = (state == ST_IDLE);
    assign resp_valid    = (state == ST_DONE);
    assign mem_ReadEn    = (state == ST_RD);
    assign mem_WriteEn   = (state == ST_WR);
    assign mem_Address   = (mem_ReadEn || mem_WriteEn) ? lat_addr[ADDR_WIDTH+1:2] : '0;
    assign mem_WriteData = !mem_WriteEn ? '0 : (lat_size == SZ_WORD) ? lat_wdata : merge_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_write  <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            merge      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        if (req_err)
                            state <= ST_DONE;
                        else if (req_write && req_size == SZ_WORD)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (lat_write) begin
                        merge <= mem_ReadData;
                        state <= ST_WR;
                    end else begin
                        resp_rdata <= load_data;
                        state      <= ST_DONE;
                    end
                end
                ST_WR:   state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMEM_LSU_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load  <= '0;
            cnt_store <= '0;
            cnt_err   <= '0;
        end else if (state == ST_DONE) begin
            if (resp_err) begin
                if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
            end else if (lat_write) begin
                if (cnt_store != 16'hFFFF) cnt_store <= cnt_store + 16'd1;
            end else begin
                if (cnt_load != 16'hFFFF) cnt_load <= cnt_load + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard bench for dmem_lsu with a behavioural memory/lane model
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [6:0]  req_addr = 7'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_WriteEn;
    logic        mem_ReadEn;
    logic [4:0]  mem_Address;
    logic [31:0] mem_WriteData;
    logic [31:0] mem_ReadData;
`ifdef DMEM_LSU_COUNTERS_EN
    logic [15:0] cnt_load, cnt_store, cnt_err;
`endif

    logic [31:0] sim_mem [32];
    logic [31:0] ref_mem [32];
    logic        mem_loaded = 1'b0;
    int cyc = 0, total = 0, bad = 0, exp_rd = 0, rd_cnt = 0;

    typedef struct {int cyc; logic err; logic [31:0] rdata;} resp_t;
    typedef struct {int cyc; logic [4:0] addr; logic [31:0] data;} wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t mon_r;
    wr_t   mon_w;

    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_WriteEn   (mem_WriteEn),
        .mem_ReadEn    (mem_ReadEn),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
`ifdef DMEM_LSU_COUNTERS_EN
        .cnt_load      (cnt_load),
        .cnt_store     (cnt_store),
        .cnt_err       (cnt_err),
`endif
        .mem_ReadData  (mem_ReadData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: preloaded with word i = i, writes on the clock edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) sim_mem[i] <= 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_WriteEn) begin
            sim_mem[mem_Address] <= mem_WriteData;
        end
    end
    assign mem_ReadData = mem_ReadEn ? sim_mem[mem_Address] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ReadEn) rd_cnt++;
            if (resp_valid) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
                    chk("resp_err", {31'd0, resp_err}, {31'd0, mon_r.err});
                    chk("resp_rdata", resp_rdata, mon_r.rdata);
                end
            end
            if (mem_WriteEn) begin
                if (wr_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
                else begin
                    mon_w = wr_q.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(mon_w.cyc));
                    chk("write_addr", {27'd0, mem_Address}, {27'd0, mon_w.addr});
                    chk("write_data", mem_WriteData, mon_w.data);
                end
            end
        end
    end

    // Reference model: computes the response and memory effect at issue time.
    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [6:0] a, input logic [31:0] d);
        int idx, off, nb, c1;
        logic err;
        logic [31:0] old, v, mask;
        resp_t r;
        wr_t wx;
        idx = int'(a) / 4;
        off = int'(a) % 4;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err = (sz == 2'b11) || (nb == 2 && off % 2 != 0) || (nb == 4 && off != 0);
        c1  = cyc + 1;
        old = ref_mem[idx];
        r.err = err;
        r.rdata = 32'h0;
        if (err) begin
            r.cyc = c1;
        end else if (!w) begin
            r.cyc = c1 + 1;
            exp_rd++;
            if (nb == 4) r.rdata = old;
            else begin
                v = (old >> (8 * off)) & ((32'h1 << (8 * nb)) - 1);
                if (sg && v[8 * nb - 1]) v = v - (32'h1 << (8 * nb));
                r.rdata = v;
            end
        end else begin
            if (nb == 4) begin
                ref_mem[idx] = d;
                r.cyc = c1 + 1;
                wx.cyc = c1;
            end else begin
                mask = ((32'h1 << (8 * nb)) - 1) << (8 * off);
                ref_mem[idx] = (old & ~mask) | ((d << (8 * off)) & mask);
                r.cyc = c1 + 2;
                wx.cyc = c1 + 1;
                exp_rd++;
            end
            wx.addr = 5'(idx);
            wx.data = ref_mem[idx];
            wr_q.push_back(wx);
        end
        resp_q.push_back(r);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        wait_ready();
        drive_req(w, sz, sg, a, d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(resp_q.size() + wr_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_enables", {30'd0, mem_WriteEn, mem_ReadEn}, 32'd0);
        chk("rst_addr_wdata", {27'd0, mem_Address} | mem_WriteData, 32'd0);
        rst_n = 1'b1;

        // Back-to-back word loads with req_valid held high: accepts every 3 cycles.
        @(negedge clk);
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, SZ_WORD, 1'b0, 7'(4 * i), 32'h0);
            if (i < 2) repeat (3) @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        issue(1'b1, SZ_WORD, 1'b0, 7'h08, 32'hA1B2C3D4);
        issue(1'b0, SZ_WORD, 1'b0, 7'h08, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 7'h09, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 7'h09, 32'h0);
        issue(1'b0, SZ_HALF, 1'b1, 7'h0A, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 7'h0A, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 7'h0B, 32'h0000005A);
        issue(1'b1, SZ_HALF, 1'b0, 7'h0C, 32'h00001234);
        issue(1'b0, SZ_HALF, 1'b0, 7'h0D, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 7'h06, 32'hDEADBEEF);
        issue(1'b0, 2'b11, 1'b0, 7'h00, 32'h0);
        drain();
        chk("mem_word2", sim_mem[2], 32'h5AB2C3D4);
        chk("mem_word3", sim_mem[3], 32'h00001234);
        chk("mem_word1", sim_mem[1], 32'h00000001);

        // Reset pulse inside the WR cycle of a byte store: no write, no response.
        @(negedge clk);
        wait_ready();
        req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 7'h10; req_wdata = 32'hFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_rd++;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        chk("wen_after_rst", {31'd0, mem_WriteEn}, 32'd0);
        issue(1'b0, SZ_WORD, 1'b0, 7'h10, 32'h0);
        drain();
        chk("mem_word4", sim_mem[4], 32'h00000004);

        for (int n = 0; n < 80; n++) begin
            logic [6:0] a;
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            a  = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~{5'd0, sz[1], sz[1] | sz[0]};
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();

        for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), sim_mem[i], ref_mem[i]);
        chk("read_enable_cycles", 32'(rd_cnt), 32'(exp_rd));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
